updown_bcd_counter: RTL and testbench

Counting stage directly upstream of the seven-segment display driver. Debounces three push-buttons and produces a registered 4-digit BCD count (0000-9999). The count steps up or down on manual presses or on a free-running auto-count tick. The display stage consumes COUNT one nibble per anode; WRAP and TICK are provided for LEDs.

---
 rtl/updown_bcd_counter.sv | 87 ++++++++
 tb/tb_updown_bcd_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_bcd_counter.sv
// updown_bcd_counter: debounced up/down/clear buttons plus auto-tick driving a 4-digit BCD count
`timescale 1ns/1ps
module updown_bcd_counter #(
  parameter int TICK_DIV = 100000000,
  parameter int DB_CYC   = 1000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        BTN_UP,
  input  logic        BTN_DN,
  input  logic        BTN_CLR,
  input  logic        SW_RUN,
  input  logic        SW_DIR,
  output logic [15:0] COUNT,
  output logic        TICK,
  output logic        WRAP
);
  localparam int DW = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYC - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  logic [4:0] meta_q, meta_d, sync_q, sync_d;
  logic [2:0] lvl_q, lvl_d, prev_q, prev_d, press_q, press_d;
  logic [DW-1:0] db_cnt_q [3];
  logic [DW-1:0] db_cnt_d [3];
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0] count_q, count_d, inc_v, dec_v;
  logic wrap_q, wrap_d, tick, run, dir, up, dn, clr, do_inc, do_dec, cy, bw;
  always_comb begin
    meta_d = {SW_DIR, SW_RUN, BTN_CLR, BTN_DN, BTN_UP};
    sync_d = meta_q;
    for (int i = 0; i < 3; i++) begin
      lvl_d[i] = (sync_q[i] != lvl_q[i] && db_cnt_q[i] == DB_LAST) ? sync_q[i] : lvl_q[i];
      db_cnt_d[i] = (sync_q[i] == lvl_q[i] || db_cnt_q[i] == DB_LAST) ? '0 : db_cnt_q[i] + 1'b1;
    end
    prev_d = lvl_q;
    press_d = lvl_q & ~prev_q;
  end
  // ripple carry/borrow across the four BCD digits
  always_comb begin
    cy = 1'b1;
    bw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inc_v[4*i +: 4] = !cy ? count_q[4*i +: 4] : (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
      dec_v[4*i +: 4] = !bw ? count_q[4*i +: 4] : (count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1;
      cy = cy & (count_q[4*i +: 4] == 4'd9);
      bw = bw & (count_q[4*i +: 4] == 4'd0);
    end
  end
  always_comb begin
    run = sync_q[3];
    dir = sync_q[4];
    {clr, dn, up} = press_q;
    tick = run && pre_q == PRE_LAST;
    pre_d = (!run || tick) ? '0 : pre_q + 1'b1;
    do_inc = !clr && (up ? !dn : !dn && tick && dir);
    do_dec = !clr && (dn ? !up : !up && tick && !dir);
    count_d = clr ? '0 : do_inc ? inc_v : do_dec ? dec_v : count_q;
    wrap_d = (do_inc && count_q == 16'h9999) || (do_dec && count_q == 16'h0000);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= '0;
      sync_q <= '0;
      lvl_q <= '0;
      prev_q <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      pre_q <= '0;
      count_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      lvl_q <= lvl_d;
      prev_q <= prev_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      pre_q <= pre_d;
      count_q <= count_d;
      wrap_q <= wrap_d;
    end
  end
  assign COUNT = count_q;
  assign TICK = tick;
  assign WRAP = wrap_q;
endmodule

// File: tb/tb_updown_bcd_counter.sv
// tb_updown_bcd_counter: vector table, directed corner sequences and a randomized run against a cycle model
`timescale 1ns/1ps
module tb_updown_bcd_counter;
  localparam int TD = 10, DB = 4, N_RND = 3000;
  logic CLK = 0, RST_N = 0, BTN_UP = 0, BTN_DN = 0, BTN_CLR = 0, SW_RUN = 0, SW_DIR = 0;
  logic [15:0] COUNT;
  logic TICK, WRAP;
  int checks = 0, errors = 0;
  typedef struct {
    logic up;
    logic dn;
    logic clr;
    logic [15:0] cnt;
    int wraps;
  } vec_t;
  vec_t tbl [14];
  logic [4:0] hist [0:N_RND];
  logic [2:0] lvh [0:N_RND];

  updown_bcd_counter #(.TICK_DIV(TD), .DB_CYC(DB)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_CLR(BTN_CLR),
    .SW_RUN(SW_RUN), .SW_DIR(SW_DIR), .COUNT(COUNT), .TICK(TICK), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [4:0] h(input int k);
    return (k >= 1) ? hist[k] : 5'd0;
  endfunction

  function automatic logic [2:0] lv(input int k);
    return (k >= 1) ? lvh[k] : 3'd0;
  endfunction

  task automatic reset_dut();
    RST_N = 0;
    repeat (3) @(negedge CLK);
    RST_N = 1;
  endtask

  task automatic press(input logic u, input logic d, input logic c, output int wraps);
    wraps = 0;
    {BTN_UP, BTN_DN, BTN_CLR} = {u, d, c};
    repeat (DB + 2) begin
      @(negedge CLK);
      wraps += int'(WRAP);
    end
    {BTN_UP, BTN_DN, BTN_CLR} = 3'b000;
    repeat (DB + 4) begin
      @(negedge CLK);
      wraps += int'(WRAP);
    end
  endtask

  task automatic tick_window(input int n, input string name);
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK);
      chk(name, 32'(TICK), 32'(k >= TD + 1 && (k - TD - 1) % TD == 0));
      chk({name, "_wrap"}, 32'(WRAP), 0);
    end
  endtask

  initial begin
    int w, n, t, cnt_m, run_len;
    int hold [3];
    logic v, tick_c, tick_n, wrap_m, flip;
    logic [2:0] bl, pr, lp;
    logic [4:0] s, hv;
    tbl[0]  = '{1, 0, 0, 16'h0001, 0};
    tbl[1]  = '{1, 0, 0, 16'h0002, 0};
    tbl[2]  = '{0, 1, 0, 16'h0001, 0};
    tbl[3]  = '{0, 1, 0, 16'h0000, 0};
    tbl[4]  = '{0, 1, 0, 16'h9999, 1};
    tbl[5]  = '{1, 0, 0, 16'h0000, 1};
    tbl[6]  = '{1, 1, 0, 16'h0000, 0};
    tbl[7]  = '{1, 0, 0, 16'h0001, 0};
    tbl[8]  = '{0, 0, 1, 16'h0000, 0};
    tbl[9]  = '{1, 0, 0, 16'h0001, 0};
    tbl[10] = '{1, 0, 1, 16'h0000, 0};
    tbl[11] = '{0, 1, 0, 16'h9999, 1};
    tbl[12] = '{1, 1, 0, 16'h9999, 0};
    tbl[13] = '{0, 0, 1, 16'h0000, 0};
    // auto-count up from reset
    SW_RUN = 1;
    SW_DIR = 1;
    #1;
    chk("reset_count", 32'(COUNT), 0);
    chk("reset_tick", 32'(TICK), 0);
    chk("reset_wrap", 32'(WRAP), 0);
    reset_dut();
    tick_window(105, "run_tick");
    chk("run_count", 32'(COUNT), 32'h0010);
    SW_RUN = 0;
    reset_dut();
    for (int i = 0; i < 14; i++) begin
      press(tbl[i].up, tbl[i].dn, tbl[i].clr, w);
      chk($sformatf("vec%0d_count", i), 32'(COUNT), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_wraps", i), w, tbl[i].wraps);
    end
    repeat (998) press(1, 0, 0, w);
    chk("preload_0998", 32'(COUNT), 32'h0998);
    press(1, 0, 0, w);
    chk("carry_0999", 32'(COUNT), 32'h0999);
    press(1, 0, 0, w);
    chk("carry_1000", 32'(COUNT), 32'h1000);
    // UP+DN pulses landing on the same cycle as a tick
    press(0, 0, 1, w);
    repeat (42) press(1, 0, 0, w);
    chk("preload_0042", 32'(COUNT), 32'h0042);
    SW_RUN = 1;
    SW_DIR = 1;
    repeat (4) @(negedge CLK);
    BTN_UP = 1;
    BTN_DN = 1;
    repeat (7) @(negedge CLK);
    chk("coinc_tick", 32'(TICK), 1);
    @(negedge CLK);
    chk("coinc_count", 32'(COUNT), 32'h0042);
    SW_RUN = 0;
    repeat (DB + 4) @(negedge CLK);
    BTN_UP = 0;
    BTN_DN = 0;
    repeat (DB + 8) @(negedge CLK);
    chk("coinc_settled", 32'(COUNT), 32'h0042);
    // bounce then steady press
    t = 0;
    v = 1;
    while (t < 20) begin
      n = $urandom_range(1, 3);
      BTN_UP = v;
      repeat (n) @(negedge CLK);
      t += n;
      v = ~v;
    end
    if (BTN_UP) begin
      BTN_UP = 0;
      @(negedge CLK);
    end
    chk("bounce_ignored", 32'(COUNT), 32'h0042);
    BTN_UP = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge CLK);
      if (i == 7) chk("bounce_early", 32'(COUNT), 32'h0042);
      if (i == 8) chk("bounce_latency", 32'(COUNT), 32'h0043);
    end
    BTN_UP = 0;
    repeat (DB + 6) @(negedge CLK);
    chk("bounce_single", 32'(COUNT), 32'h0043);
    // auto-count down through zero
    press(0, 0, 1, w);
    SW_RUN = 1;
    SW_DIR = 0;
    n = 0;
    while (COUNT == 16'h0000 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk("dn_first_latency", n, 12);
    chk("dn_wrap_count", 32'(COUNT), 32'h9999);
    chk("dn_wrap_pulse", 32'(WRAP), 1);
    n = 0;
    while (COUNT == 16'h9999 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk("dn_second_latency", n, 10);
    chk("dn_second_count", 32'(COUNT), 32'h9998);
    chk("dn_second_wrap", 32'(WRAP), 0);
    SW_RUN = 0;
    repeat (4) @(negedge CLK);
    // asynchronous reset during a tick cycle
    press(0, 0, 1, w);
    repeat (537) press(1, 0, 0, w);
    chk("preload_0537", 32'(COUNT), 32'h0537);
    SW_RUN = 1;
    SW_DIR = 1;
    repeat (11) @(negedge CLK);
    chk("pre_reset_tick", 32'(TICK), 1);
    #2;
    RST_N = 0;
    #1;
    chk("async_count", 32'(COUNT), 0);
    chk("async_tick", 32'(TICK), 0);
    chk("async_wrap", 32'(WRAP), 0);
    @(negedge CLK);
    RST_N = 1;
    tick_window(15, "restart_tick");
    chk("restart_count", 32'(COUNT), 32'h0001);
    // randomized run against the cycle model
    SW_RUN = 0;
    SW_DIR = 0;
    reset_dut();
    for (int b = 0; b < 3; b++) hold[b] = 0;
    bl = 0;
    cnt_m = 0;
    run_len = 0;
    for (int e = 1; e <= N_RND; e++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          bl[b] = (b == 2) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 10);
        end
        hold[b]--;
      end
      if ($urandom_range(0, 99) == 0) SW_RUN = ~SW_RUN;
      if ($urandom_range(0, 99) == 0) SW_DIR = ~SW_DIR;
      {BTN_CLR, BTN_DN, BTN_UP} = bl;
      hist[e] = {SW_DIR, SW_RUN, bl};
      @(negedge CLK);
      s = h(e - 2);
      run_len = s[3] ? run_len + 1 : 0;
      tick_c = s[3] && (run_len % TD == 0);
      lp = lv(e - 1);
      for (int b = 0; b < 3; b++) begin
        flip = 1;
        for (int j = 0; j < DB; j++) begin
          hv = h(e - 2 - j);
          if (hv[b] == lp[b]) flip = 0;
        end
        lvh[e][b] = lp[b] ^ flip;
      end
      pr = lv(e - 2) & ~lv(e - 3);
      wrap_m = 0;
      if (pr[2]) cnt_m = 0;
      else if (pr[0] && pr[1]) begin
      end else if (pr[0] || (!pr[1] && tick_c && s[4])) begin
        wrap_m = (cnt_m == 9999);
        cnt_m = (cnt_m + 1) % 10000;
      end else if (pr[1] || (tick_c && !s[4])) begin
        wrap_m = (cnt_m == 0);
        cnt_m = (cnt_m + 9999) % 10000;
      end
      hv = h(e - 1);
      tick_n = hv[3] && ((run_len + 1) % TD == 0);
      chk("rnd_count", 32'(COUNT), 32'(to_bcd(cnt_m)));
      chk("rnd_wrap", 32'(WRAP), 32'(wrap_m));
      chk("rnd_tick", 32'(TICK), 32'(tick_n));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
